// File: rtl/lane_game_core.sv
// Lane-crossing game core: player/state FSM, scrolling obstacle lanes with
// per-lane direction and speed, and a registered single-pixel query port.
module lane_game_core #(
  parameter int unsigned COLS  = 20,
  parameter int unsigned ROWS  = 15,
  parameter int unsigned LIVES = 3,
  localparam int unsigned CW   = $clog2(COLS),
  localparam int unsigned RW   = $clog2(ROWS),
  localparam int unsigned LW   = $clog2(LIVES + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_btn_u,
  input  logic            i_btn_d,
  input  logic            i_btn_l,
  input  logic            i_btn_r,
  input  logic            i_mv_tick,
  input  logic            i_obs_tick,
  input  logic            i_cfg_we,
  input  logic [RW-1:0]   i_cfg_row,
  input  logic [COLS-1:0] i_cfg_pat,
  input  logic            i_cfg_dir,
  input  logic [1:0]      i_cfg_spd,
  input  logic [CW-1:0]   i_q_col,
  input  logic [RW-1:0]   i_q_row,
  output logic            o_q_obs,
  output logic            o_q_player,
  output logic [CW-1:0]   o_player_x,
  output logic [RW-1:0]   o_player_y,
  output logic [LW-1:0]   o_lives,
  output logic [3:0]      o_wins,
  output logic [1:0]      o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_WIN  = 2'b10,
    S_OVER = 2'b11
  } state_t;

  localparam logic [CW-1:0] X_START = CW'(COLS / 2);
  localparam logic [CW-1:0] X_MAX   = CW'(COLS - 1);
  localparam logic [RW-1:0] Y_START = RW'(ROWS - 1);
  localparam logic [LW-1:0] L_FULL  = LW'(LIVES);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_px, w_px_nxt;
  logic [RW-1:0]   r_py, w_py_nxt;
  logic [LW-1:0]   r_lives, w_lives_nxt;
  logic [3:0]      r_wins, w_wins_nxt;
  logic            r_q_obs, r_q_player;

  logic [COLS-1:0] r_lane   [ROWS];
  logic [COLS-1:0] r_shadow [ROWS];
  logic            r_dir    [ROWS];
  logic [1:0]      r_spd    [ROWS];
  logic [1:0]      r_cnt    [ROWS];

  logic [COLS-1:0] w_py_lane;
  logic [COLS-1:0] w_q_lane;
  logic [ROWS-1:0] w_cfg_hit;
  logic            w_hit;
  logic            w_start_game;
  logic            w_q_valid;

  function automatic logic [COLS-1:0] rotate(input logic [COLS-1:0] p, input logic dir);
    return dir ? {p[COLS-2:0], p[COLS-1]} : {p[0], p[COLS-1:1]};
  endfunction

  // Row lookups for the player's lane and the query lane
  always_comb begin
    w_py_lane = '0;
    w_q_lane  = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (r_py == RW'(r))    w_py_lane = r_lane[r];
      if (i_q_row == RW'(r)) w_q_lane  = r_lane[r];
    end
  end

  // Edge rows are never writable, so they stay obstacle-free
  always_comb begin
    w_cfg_hit = '0;
    for (int r = 1; r < int'(ROWS) - 1; r++) begin
      w_cfg_hit[r] = (r_state == S_IDLE) && i_cfg_we && (i_cfg_row == RW'(r));
    end
  end

  assign w_hit        = w_py_lane[r_px];
  assign w_start_game = (r_state == S_IDLE) && i_start;
  assign w_q_valid    = ({1'b0, i_q_col} < (CW + 1)'(COLS)) &&
                        ({1'b0, i_q_row} < (RW + 1)'(ROWS));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_px    <= X_START;
      r_py    <= Y_START;
      r_lives <= L_FULL;
      r_wins  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_px    <= w_px_nxt;
      r_py    <= w_py_nxt;
      r_lives <= w_lives_nxt;
      r_wins  <= w_wins_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_lives_nxt = r_lives;
    w_wins_nxt  = r_wins;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_PLAY;
          w_lives_nxt = L_FULL;
          w_px_nxt    = X_START;
          w_py_nxt    = Y_START;
        end
      end
      S_PLAY: begin
        if (!i_start) begin
          w_state_nxt = S_IDLE;
          w_px_nxt    = X_START;
          w_py_nxt    = Y_START;
        end else if (w_hit) begin
          // A hit pre-empts any move requested in the same cycle
          if (r_lives > LW'(1)) begin
            w_lives_nxt = r_lives - LW'(1);
            w_px_nxt    = X_START;
            w_py_nxt    = Y_START;
          end else begin
            w_lives_nxt = '0;
            w_state_nxt = S_OVER;
          end
        end else if (r_py == '0) begin
          w_state_nxt = S_WIN;
          if (r_wins != 4'd15) w_wins_nxt = r_wins + 4'd1;
        end else if (i_mv_tick) begin
          if (i_btn_d && !i_btn_u && (r_py < Y_START))      w_py_nxt = r_py + RW'(1);
          else if (i_btn_u && !i_btn_d && (r_py != '0))     w_py_nxt = r_py - RW'(1);
          else if (i_btn_r && !i_btn_l && (r_px < X_MAX))   w_px_nxt = r_px + CW'(1);
          else if (i_btn_l && !i_btn_r && (r_px != '0))     w_px_nxt = r_px - CW'(1);
        end
      end
      default: begin
        if (!i_start) begin
          w_state_nxt = S_IDLE;
          w_px_nxt    = X_START;
          w_py_nxt    = Y_START;
        end
      end
    endcase
  end

  // Lane storage: config writes, reload on game start, rotation while playing
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        r_lane[r]   <= '0;
        r_shadow[r] <= '0;
        r_dir[r]    <= 1'b0;
        r_spd[r]    <= '0;
        r_cnt[r]    <= '0;
      end
    end else begin
      for (int r = 1; r < int'(ROWS) - 1; r++) begin
        if (w_start_game) r_cnt[r] <= '0;
        if (w_cfg_hit[r]) begin
          r_shadow[r] <= i_cfg_pat;
          r_lane[r]   <= i_cfg_pat;
          r_dir[r]    <= i_cfg_dir;
          r_spd[r]    <= i_cfg_spd;
        end else if (w_start_game) begin
          r_lane[r] <= r_shadow[r];
        end else if ((r_state == S_PLAY) && i_obs_tick) begin
          if (r_cnt[r] == r_spd[r]) begin
            r_cnt[r]  <= '0;
            r_lane[r] <= rotate(r_lane[r], r_dir[r]);
          end else begin
            r_cnt[r] <= r_cnt[r] + 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_q_obs    <= 1'b0;
      r_q_player <= 1'b0;
    end else begin
      r_q_obs    <= w_q_valid && w_q_lane[i_q_col];
      r_q_player <= w_q_valid && (i_q_col == r_px) && (i_q_row == r_py);
    end
  end

  assign o_q_obs    = r_q_obs;
  assign o_q_player = r_q_player;
  assign o_player_x = r_px;
  assign o_player_y = r_py;
  assign o_lives    = r_lives;
  assign o_wins     = r_wins;
  assign o_state    = r_state;

endmodule

// File: tb/tb_lane_game_core.sv
// Self-checking bench for lane_game_core: move/query vector tables, a query
// scoreboard, and hand-written sequences for lanes, collisions and reset.
module tb_lane_game_core;

  localparam int unsigned COLS = 20;
  localparam int unsigned ROWS = 15;
  localparam int unsigned CW   = 5;
  localparam int unsigned RW   = 4;
  localparam int unsigned LW   = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic            mv_tick = 1'b0, obs_tick = 1'b0;
  logic            cfg_we = 1'b0;
  logic [RW-1:0]   cfg_row = '0;
  logic [COLS-1:0] cfg_pat = '0;
  logic            cfg_dir = 1'b0;
  logic [1:0]      cfg_spd = '0;
  logic [CW-1:0]   q_col = '0;
  logic [RW-1:0]   q_row = '0;
  logic            q_obs, q_player;
  logic [CW-1:0]   player_x;
  logic [RW-1:0]   player_y;
  logic [LW-1:0]   lives;
  logic [3:0]      wins;
  logic [1:0]      state;

  int n_checks = 0;
  int n_errors = 0;

  lane_game_core #(.COLS(COLS), .ROWS(ROWS), .LIVES(3)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_btn_u(btn_u), .i_btn_d(btn_d), .i_btn_l(btn_l), .i_btn_r(btn_r),
    .i_mv_tick(mv_tick), .i_obs_tick(obs_tick),
    .i_cfg_we(cfg_we), .i_cfg_row(cfg_row), .i_cfg_pat(cfg_pat),
    .i_cfg_dir(cfg_dir), .i_cfg_spd(cfg_spd),
    .i_q_col(q_col), .i_q_row(q_row),
    .o_q_obs(q_obs), .o_q_player(q_player),
    .o_player_x(player_x), .o_player_y(player_y),
    .o_lives(lives), .o_wins(wins), .o_state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mv, u, d, l, r;
    int   ex, ey;
  } mv_vec_t;

  typedef struct {
    int   col, row;
    logic eo, ep;
  } q_vec_t;

  typedef struct {
    string nm;
    logic  eo, ep;
  } q_exp_t;

  q_exp_t  sb[$];
  mv_vec_t mt[10];
  q_vec_t  qt[13];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0; mv_tick = 1'b0; obs_tick = 1'b0; cfg_we = 1'b0;
    btn_u = 1'b0; btn_d = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic cfg(input int row, input logic [COLS-1:0] pat, input logic dir, input logic [1:0] spd);
    cfg_we = 1'b1; cfg_row = RW'(row); cfg_pat = pat; cfg_dir = dir; cfg_spd = spd;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic query(input string nm, input int col, input int row, input logic eo, input logic ep);
    q_exp_t e;
    q_col = CW'(col);
    q_row = RW'(row);
    sb.push_back('{nm, eo, ep});
    step(1);
    if (sb.size() == 0) begin
      chk({nm, " scoreboard"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.nm, " q_obs"}, int'(q_obs), int'(e.eo));
      chk({e.nm, " q_player"}, int'(q_player), int'(e.ep));
    end
  endtask

  task automatic hold_move(input logic u, input logic d, input logic l, input logic r, input int n);
    btn_u = u; btn_d = d; btn_l = l; btn_r = r; mv_tick = 1'b1;
    step(n);
    mv_tick = 1'b0; btn_u = 1'b0; btn_d = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10, 14};
    mt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10, 14};
    mt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10, 14};
    mt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10, 14};
    mt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11, 14};
    mt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11, 13};
    mt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11, 12};
    mt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 11, 13};
    mt[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10, 13};
    mt[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  9, 13};

    qt[0]  = '{10, 14, 1'b0, 1'b1};
    qt[1]  = '{ 0,  7, 1'b1, 1'b0};
    qt[2]  = '{ 1,  7, 1'b0, 1'b0};
    qt[3]  = '{19,  3, 1'b1, 1'b0};
    qt[4]  = '{ 0,  3, 1'b0, 1'b0};
    qt[5]  = '{ 0,  9, 1'b1, 1'b0};
    qt[6]  = '{ 4,  5, 1'b0, 1'b0};
    qt[7]  = '{19,  5, 1'b1, 1'b0};
    qt[8]  = '{ 0,  0, 1'b0, 1'b0};
    qt[9]  = '{ 5, 14, 1'b0, 1'b0};
    qt[10] = '{25,  7, 1'b0, 1'b0};
    qt[11] = '{10, 15, 1'b0, 1'b0};
    qt[12] = '{25, 14, 1'b0, 1'b0};

    // Reset state, with start held high while reset is asserted
    start = 1'b1;
    step(2);
    chk("rst state", int'(state), 0);
    chk("rst lives", int'(lives), 3);
    chk("rst wins", int'(wins), 0);
    chk("rst x", int'(player_x), 10);
    chk("rst y", int'(player_y), 14);
    chk("rst q_obs", int'(q_obs), 0);
    chk("rst q_player", int'(q_player), 0);
    start = 1'b0;
    reset = 1'b0;
    step(1);

    // Lane config in IDLE, including writes to the fixed edge rows
    cfg(7, 20'h00001, 1'b1, 2'd1);
    cfg(3, 20'h80000, 1'b1, 2'd0);
    cfg(9, 20'h00001, 1'b0, 2'd0);
    cfg(5, 20'hF0F0F, 1'b0, 2'd0);
    cfg(0, 20'hFFFFF, 1'b0, 2'd0);
    cfg(14, 20'hFFFFF, 1'b0, 2'd0);
    foreach (qt[i]) begin
      query($sformatf("qtab%0d", i), qt[i].col, qt[i].row, qt[i].eo, qt[i].ep);
    end

    // Lane rotation in PLAY
    start = 1'b1;
    step(1);
    chk("lane play state", int'(state), 1);
    obs_tick = 1'b1; step(1); obs_tick = 1'b0;
    query("tick1 row3 b0", 0, 3, 1'b1, 1'b0);
    query("tick1 row3 b19", 19, 3, 1'b0, 1'b0);
    query("tick1 row7 b0", 0, 7, 1'b1, 1'b0);
    obs_tick = 1'b1; step(3); obs_tick = 1'b0;
    query("tick4 row7 b2", 2, 7, 1'b1, 1'b0);
    query("tick4 row7 b0", 0, 7, 1'b0, 1'b0);
    query("tick4 row3 b3", 3, 3, 1'b1, 1'b0);
    query("tick4 row9 b16", 16, 9, 1'b1, 1'b0);
    cfg(7, 20'hFFFFF, 1'b0, 2'd0);
    query("cfg in play ignored", 5, 7, 1'b0, 1'b0);
    start = 1'b0;
    step(1);
    chk("back to idle", int'(state), 0);
    obs_tick = 1'b1; step(2); obs_tick = 1'b0;
    query("idle frozen row7 b2", 2, 7, 1'b1, 1'b0);
    start = 1'b1;
    step(1);
    query("reload row7 b0", 0, 7, 1'b1, 1'b0);
    query("reload row7 b2", 2, 7, 1'b0, 1'b0);

    // Move table and board edges on empty lanes
    do_reset();
    start = 1'b1;
    step(1);
    foreach (mt[i]) begin
      btn_u = mt[i].u; btn_d = mt[i].d; btn_l = mt[i].l; btn_r = mt[i].r; mv_tick = mt[i].mv;
      step(1);
      mv_tick = 1'b0;
      chk($sformatf("mtab%0d x", i), int'(player_x), mt[i].ex);
      chk($sformatf("mtab%0d y", i), int'(player_y), mt[i].ey);
    end
    hold_move(1'b0, 1'b0, 1'b0, 1'b1, 10);
    chk("right to edge x", int'(player_x), 19);
    hold_move(1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("right at edge x", int'(player_x), 19);
    hold_move(1'b0, 1'b0, 1'b1, 1'b0, 19);
    chk("left to edge x", int'(player_x), 0);
    hold_move(1'b0, 1'b0, 1'b1, 1'b0, 1);
    chk("left at edge x", int'(player_x), 0);
    chk("edges y", int'(player_y), 13);

    // Three wins on empty lanes, then a hit, then reset mid-game
    do_reset();
    for (int g = 0; g < 3; g++) begin
      start = 1'b1;
      step(1);
      chk($sformatf("g%0d play", g), int'(state), 1);
      hold_move(1'b1, 1'b0, 1'b0, 1'b0, 14);
      chk($sformatf("g%0d top y", g), int'(player_y), 0);
      step(1);
      chk($sformatf("g%0d win state", g), int'(state), 2);
      chk($sformatf("g%0d wins", g), int'(wins), g + 1);
      start = 1'b0;
      step(1);
      chk($sformatf("g%0d idle", g), int'(state), 0);
      chk($sformatf("g%0d home y", g), int'(player_y), 14);
    end
    cfg(13, 20'hFFFFF, 1'b0, 2'd0);
    start = 1'b1;
    step(1);
    hold_move(1'b1, 1'b0, 1'b0, 1'b0, 1);
    step(1);
    chk("pre-rst lives", int'(lives), 2);
    chk("pre-rst wins", int'(wins), 3);
    query("pre-rst row13", 10, 13, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("async rst state", int'(state), 0);
    chk("async rst lives", int'(lives), 3);
    chk("async rst wins", int'(wins), 0);
    chk("async rst q_obs", int'(q_obs), 0);
    chk("async rst y", int'(player_y), 14);
    start = 1'b0;
    step(1);
    reset = 1'b0;
    query("lanes cleared", 10, 13, 1'b0, 1'b0);

    // Collisions down to game over; a move in the hit cycle is dropped
    cfg(13, 20'hFFFFF, 1'b0, 2'd3);
    start = 1'b1;
    step(1);
    hold_move(1'b1, 1'b0, 1'b0, 1'b0, 1);
    chk("hit1 enter y", int'(player_y), 13);
    hold_move(1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("hit1 lives", int'(lives), 2);
    chk("hit1 x", int'(player_x), 10);
    chk("hit1 y", int'(player_y), 14);
    hold_move(1'b1, 1'b0, 1'b0, 1'b0, 1);
    step(1);
    chk("hit2 lives", int'(lives), 1);
    hold_move(1'b1, 1'b0, 1'b0, 1'b0, 1);
    step(1);
    chk("hit3 lives", int'(lives), 0);
    chk("hit3 state", int'(state), 3);
    step(2);
    chk("over holds", int'(state), 3);

    // Move and lane shift in the same cycle: judged on new positions
    do_reset();
    cfg(13, 20'h00400, 1'b1, 2'd0);
    start = 1'b1;
    step(1);
    obs_tick = 1'b1;
    hold_move(1'b1, 1'b0, 1'b0, 1'b0, 1);
    obs_tick = 1'b0;
    chk("same-cycle y", int'(player_y), 13);
    step(1);
    chk("same-cycle lives", int'(lives), 3);
    chk("same-cycle state", int'(state), 1);
    query("same-cycle lane", 11, 13, 1'b1, 1'b0);
    query("same-cycle player", 10, 13, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
